// File: rtl/m_memcode_server_pkg.sv
// Shared widths and types for the memory-code server and its arbiter.
package m_memcode_server_pkg;

  localparam int unsigned MEMCODE_ADDR_W = 14;
  localparam int unsigned MEMCODE_DATA_W = 32;
  localparam int unsigned CH_NUM_MAX     = 16;

  // Who owns the SRAM port in the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE    = 2'd0,
    SRC_HOST_WR = 2'd1,
    SRC_HOST_RD = 2'd2,
    SRC_CH      = 2'd3
  } mem_src_e;

  typedef struct packed {
    logic                      cs;
    logic                      we;
    logic [MEMCODE_ADDR_W-1:0] addr;
    logic [MEMCODE_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/m_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, with wrap.
module m_rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_c_o,
  output logic [IDX_W-1:0] idx_c_o,
  output logic             vld_c_o
);

  logic [IDX_W:0] j;

  always_comb begin
    gnt_c_o = '0;
    idx_c_o = '0;
    vld_c_o = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (j >= (IDX_W+1)'(N)) j = j - (IDX_W+1)'(N);
      if (!vld_c_o && req_i[j[IDX_W-1:0]]) begin
        vld_c_o               = 1'b1;
        gnt_c_o[j[IDX_W-1:0]] = 1'b1;
        idx_c_o               = j[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/m_memcode_server.sv
// Arbitrates channel code reads and host accesses onto one single-port code SRAM.
// Optional host read path: MEMCODE_HOST_READ_EN.
module m_memcode_server
  import m_memcode_server_pkg::*;
#(
  parameter int unsigned CH_NUM = 4
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic [CH_NUM-1:0]                ch_memcode_rd,
  input  logic [MEMCODE_ADDR_W*CH_NUM-1:0] ch_memcode_addr,
  output logic [CH_NUM-1:0]                ch_memcode_read_valid,
  output logic [MEMCODE_DATA_W-1:0]        memcode_data,
  input  logic                             host_wr,
  input  logic [MEMCODE_ADDR_W-1:0]        host_addr,
  input  logic [MEMCODE_DATA_W-1:0]        host_wdata,
`ifdef MEMCODE_HOST_READ_EN
  input  logic                             host_rd,
  output logic [MEMCODE_DATA_W-1:0]        host_rdata,
  output logic                             host_rdata_valid,
`endif
  output logic                             mem_cs,
  output logic                             mem_we,
  output logic [MEMCODE_ADDR_W-1:0]        mem_addr,
  output logic [MEMCODE_DATA_W-1:0]        mem_wdata,
  input  logic [MEMCODE_DATA_W-1:0]        mem_rdata
);

  localparam int unsigned IDX_W = $clog2(CH_NUM);

  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic                      grant_d_q, grant_d_d;
  logic [MEMCODE_DATA_W-1:0] data_hold_q, data_hold_d;
  logic [CH_NUM-1:0]         arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_vld;
  logic                      host_rd_req;
  mem_src_e                  src;
  mem_req_t                  mem_req;

`ifdef MEMCODE_HOST_READ_EN
  assign host_rd_req = host_rd;
`else
  assign host_rd_req = 1'b0;
`endif

  m_rr_arbiter #(.N(CH_NUM)) u_arb (
    .req_i   (ch_memcode_rd),
    .ptr_i   (rr_ptr_q),
    .gnt_c_o (arb_gnt),
    .idx_c_o (arb_idx),
    .vld_c_o (arb_vld)
  );

  // Port ownership: host write > host read > channel; channels also wait out the data cycle.
  always_comb begin
    src                   = SRC_NONE;
    mem_req               = '0;
    ch_memcode_read_valid = '0;
    rr_ptr_d              = rr_ptr_q;
    grant_d_d             = 1'b0;
    data_hold_d           = grant_d_q ? mem_rdata : data_hold_q;

    if (!rst_b)                     src = SRC_NONE;
    else if (host_wr)               src = SRC_HOST_WR;
    else if (host_rd_req)           src = SRC_HOST_RD;
    else if (arb_vld && !grant_d_q) src = SRC_CH;

    unique case (src)
      SRC_NONE: ;
      SRC_HOST_WR: begin
        mem_req.cs    = 1'b1;
        mem_req.we    = 1'b1;
        mem_req.addr  = host_addr;
        mem_req.wdata = host_wdata;
      end
      SRC_HOST_RD: begin
        mem_req.cs   = 1'b1;
        mem_req.addr = host_addr;
      end
      SRC_CH: begin
        mem_req.cs            = 1'b1;
        mem_req.addr          = ch_memcode_addr[32'(arb_idx)*MEMCODE_ADDR_W +: MEMCODE_ADDR_W];
        ch_memcode_read_valid = arb_gnt;
        grant_d_d             = 1'b1;
        rr_ptr_d              = (32'(arb_idx) == CH_NUM - 1) ? '0 : arb_idx + IDX_W'(1);
      end
    endcase
  end

  assign mem_cs       = mem_req.cs;
  assign mem_we       = mem_req.we;
  assign mem_addr     = mem_req.addr;
  assign mem_wdata    = mem_req.wdata;
  assign memcode_data = grant_d_q ? mem_rdata : data_hold_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr_q    <= '0;
      grant_d_q   <= 1'b0;
      data_hold_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      grant_d_q   <= grant_d_d;
      data_hold_q <= data_hold_d;
    end
  end

`ifdef MEMCODE_HOST_READ_EN
  logic                      host_rd_q, host_rd_d;
  logic                      host_rdata_valid_q, host_rdata_valid_d;
  logic [MEMCODE_DATA_W-1:0] host_rdata_q, host_rdata_d;

  // Host read data lands one cycle after issue and is registered one more cycle.
  always_comb begin
    host_rd_d          = (src == SRC_HOST_RD);
    host_rdata_valid_d = host_rd_q;
    host_rdata_d       = host_rd_q ? mem_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      host_rd_q          <= 1'b0;
      host_rdata_valid_q <= 1'b0;
      host_rdata_q       <= '0;
    end else begin
      host_rd_q          <= host_rd_d;
      host_rdata_valid_q <= host_rdata_valid_d;
      host_rdata_q       <= host_rdata_d;
    end
  end

  assign host_rdata       = host_rdata_q;
  assign host_rdata_valid = host_rdata_valid_q;
`endif

endmodule

// File: tb/tb_m_memcode_server.sv
// Directed bench for m_memcode_server (CH_NUM=4) with a 1-cycle-latency SRAM model.
module tb_m_memcode_server;

  logic        clk;
  logic        rst_b;
  logic [3:0]  ch_rd;
  logic [55:0] ch_addr;
  logic [3:0]  rd_valid;
  logic [31:0] memcode_data;
  logic        host_wr;
  logic [13:0] host_addr;
  logic [31:0] host_wdata;
  logic        mem_cs, mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef MEMCODE_HOST_READ_EN
  logic        host_rd;
  logic [31:0] host_rdata;
  logic        host_rdata_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;

  m_memcode_server #(.CH_NUM(4)) dut (
    .clk                   (clk),
    .rst_b                 (rst_b),
    .ch_memcode_rd         (ch_rd),
    .ch_memcode_addr       (ch_addr),
    .ch_memcode_read_valid (rd_valid),
    .memcode_data          (memcode_data),
    .host_wr               (host_wr),
    .host_addr             (host_addr),
    .host_wdata            (host_wdata),
`ifdef MEMCODE_HOST_READ_EN
    .host_rd               (host_rd),
    .host_rdata            (host_rdata),
    .host_rdata_valid      (host_rdata_valid),
`endif
    .mem_cs                (mem_cs),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: unwritten words read back a fixed pattern; output holds between reads.
  logic [31:0] sram [0:16383];
  bit          written [0:16383];

  function automatic logic [31:0] code_word(input logic [13:0] a);
    if (a == 14'h0020) return 32'hA5A5_0001;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        sram[mem_addr]    <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? sram[mem_addr] : code_word(mem_addr);
      end
    end
  end

  typedef struct {
    logic [3:0]  rd;
    logic        hw;
    logic [13:0] ha;
    logic [31:0] hd;
    logic [3:0]  ev;
    logic        ecs;
    logic        ewe;
    logic [13:0] ea;
    logic [31:0] ewd;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic [3:0] rd, input logic hw, input logic [13:0] ha,
                              input logic [31:0] hd, input logic [3:0] ev, input logic ecs,
                              input logic ewe, input logic [13:0] ea, input logic [31:0] ewd,
                              input logic [31:0] ed);
    vec_t v;
    v.rd = rd; v.hw = hw; v.ha = ha; v.hd = hd; v.ev = ev;
    v.ecs = ecs; v.ewe = ewe; v.ea = ea; v.ewd = ewd; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] rd, input logic hw, input logic [13:0] ha,
                       input logic [31:0] hd);
    ch_rd      = rd;
    host_wr    = hw;
    host_addr  = ha;
    host_wdata = hd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ch3..ch0 addresses
    ch_addr = {14'h0033, 14'h0042, 14'h0100, 14'h0020};
`ifdef MEMCODE_HOST_READ_EN
    host_rd = 1'b0;
`endif
    // all four request, round-robin from ch0
    vecs[0]  = mk(4'hF, 0, 14'h0, 32'h0, 4'h1, 1, 0, 14'h020, 32'h0, 32'h0);
    vecs[1]  = mk(4'hE, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hA5A5_0001);
    vecs[2]  = mk(4'hE, 0, 14'h0, 32'h0, 4'h2, 1, 0, 14'h100, 32'h0, 32'hA5A5_0001);
    vecs[3]  = mk(4'hC, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hC0DE_0100);
    vecs[4]  = mk(4'hC, 0, 14'h0, 32'h0, 4'h4, 1, 0, 14'h042, 32'h0, 32'hC0DE_0100);
    vecs[5]  = mk(4'h8, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hC0DE_0042);
    vecs[6]  = mk(4'h8, 0, 14'h0, 32'h0, 4'h8, 1, 0, 14'h033, 32'h0, 32'hC0DE_0042);
    vecs[7]  = mk(4'h1, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hC0DE_0033);
    vecs[8]  = mk(4'h1, 0, 14'h0, 32'h0, 4'h1, 1, 0, 14'h020, 32'h0, 32'hC0DE_0033);
    vecs[9]  = mk(4'h0, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hA5A5_0001);
    // host write beats ch1; ch1 then reads the new word; host write right after a grant
    vecs[10] = mk(4'h2, 1, 14'h100, 32'h1234_5678, 4'h0, 1, 1, 14'h100, 32'h1234_5678, 32'hA5A5_0001);
    vecs[11] = mk(4'h2, 0, 14'h0, 32'h0, 4'h2, 1, 0, 14'h100, 32'h0, 32'hA5A5_0001);
    vecs[12] = mk(4'h0, 1, 14'h200, 32'hDEAD_BEEF, 4'h0, 1, 1, 14'h200, 32'hDEAD_BEEF, 32'h1234_5678);
    vecs[13] = mk(4'h0, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'h1234_5678);
    // ch2 holds rd through the blocked cycle
    vecs[14] = mk(4'h4, 0, 14'h0, 32'h0, 4'h4, 1, 0, 14'h042, 32'h0, 32'h1234_5678);
    vecs[15] = mk(4'h4, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hC0DE_0042);
    vecs[16] = mk(4'h4, 0, 14'h0, 32'h0, 4'h4, 1, 0, 14'h042, 32'h0, 32'hC0DE_0042);
    vecs[17] = mk(4'h0, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hC0DE_0042);
    // pointer at 3 with only ch0/ch1 requesting: wraps to ch0
    vecs[18] = mk(4'h3, 0, 14'h0, 32'h0, 4'h1, 1, 0, 14'h020, 32'h0, 32'hC0DE_0042);
    vecs[19] = mk(4'h2, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'hA5A5_0001);
    vecs[20] = mk(4'h2, 0, 14'h0, 32'h0, 4'h2, 1, 0, 14'h100, 32'h0, 32'hA5A5_0001);
    vecs[21] = mk(4'h0, 0, 14'h0, 32'h0, 4'h0, 0, 0, 14'h000, 32'h0, 32'h1234_5678);

    // reset: outputs forced to zero even with active inputs
    rst_b = 1'b0;
    drive(4'hF, 1, 14'h1FF, 32'hFFFF_FFFF);
    #3;
    chk("reset valid", 32'(rd_valid), 32'h0);
    chk("reset data", memcode_data, 32'h0);
    chk("reset cs", 32'(mem_cs), 32'h0);
    chk("reset we", 32'(mem_we), 32'h0);
    chk("reset addr", 32'(mem_addr), 32'h0);
    chk("reset wdata", mem_wdata, 32'h0);
    @(posedge clk);
    next_cycle();
    rst_b = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].rd, vecs[i].hw, vecs[i].ha, vecs[i].hd);
      #3;
      chk($sformatf("c%0d valid", i), 32'(rd_valid), 32'(vecs[i].ev));
      chk($sformatf("c%0d cs", i), 32'(mem_cs), 32'(vecs[i].ecs));
      chk($sformatf("c%0d we", i), 32'(mem_we), 32'(vecs[i].ewe));
      chk($sformatf("c%0d addr", i), 32'(mem_addr), 32'(vecs[i].ea));
      chk($sformatf("c%0d wdata", i), mem_wdata, vecs[i].ewd);
      chk($sformatf("c%0d data", i), memcode_data, vecs[i].ed);
      next_cycle();
    end

    // reset right after a ch2 grant (pointer would otherwise be 3)
    drive(4'h4, 0, 14'h0, 32'h0);
    #3;
    chk("rst-seq grant ch2", 32'(rd_valid), 32'h4);
    next_cycle();
    rst_b = 1'b0;
    #1;
    chk("rst-seq data", memcode_data, 32'h0);
    chk("rst-seq valid", 32'(rd_valid), 32'h0);
    chk("rst-seq cs", 32'(mem_cs), 32'h0);
    next_cycle();
    rst_b = 1'b1;
    drive(4'h9, 0, 14'h0, 32'h0);
    #2;
    chk("post-rst grant ch0", 32'(rd_valid), 32'h1);
    chk("post-rst addr", 32'(mem_addr), 32'h020);
    next_cycle();
    drive(4'h0, 0, 14'h0, 32'h0);
    #2;
    chk("post-rst data", memcode_data, 32'hA5A5_0001);
    next_cycle();

`ifdef MEMCODE_HOST_READ_EN
    // host read of 0x0100 concurrent with ch3
    drive(4'h8, 0, 14'h100, 32'h0);
    host_rd = 1'b1;
    #2;
    chk("hrd valid", 32'(rd_valid), 32'h0);
    chk("hrd cs", 32'(mem_cs), 32'h1);
    chk("hrd we", 32'(mem_we), 32'h0);
    chk("hrd addr", 32'(mem_addr), 32'h100);
    chk("hrd data", memcode_data, 32'hA5A5_0001);
    next_cycle();
    host_rd = 1'b0;
    #2;
    chk("hrd+1 grant ch3", 32'(rd_valid), 32'h8);
    chk("hrd+1 rvalid", 32'(host_rdata_valid), 32'h0);
    chk("hrd+1 data", memcode_data, 32'hA5A5_0001);
    next_cycle();
    drive(4'h0, 0, 14'h0, 32'h0);
    #2;
    chk("hrd+2 rvalid", 32'(host_rdata_valid), 32'h1);
    chk("hrd+2 rdata", host_rdata, 32'h1234_5678);
    chk("hrd+2 data", memcode_data, 32'hC0DE_0033);
    next_cycle();
    chk("hrd+3 rvalid", 32'(host_rdata_valid), 32'h0);
    // write and read together: write wins, read dropped
    drive(4'h0, 1, 14'h300, 32'h0000_0055);
    host_rd = 1'b1;
    #2;
    chk("wr+rd we", 32'(mem_we), 32'h1);
    chk("wr+rd wdata", mem_wdata, 32'h0000_0055);
    next_cycle();
    host_rd = 1'b0;
    drive(4'h0, 0, 14'h0, 32'h0);
    next_cycle();
    #2;
    chk("wr+rd rvalid", 32'(host_rdata_valid), 32'h0);
    next_cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
